// File: rtl/alu_md_pkg.sv
// Shared codes for alu_md: ALU operation select, multiply/divide op select
// and the iterative engine's state encoding.
package alu_md_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine. A request accepted at edge E0 spends one
// cycle in IDLE loading operand magnitudes, WIDTH cycles in CALC (one
// shift-add or restoring step each), one cycle in FIX applying signs, then
// shows the result in DONE at E0+WIDTH+2. Divide by zero goes load->FIX->DONE.
module muldiv_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic             load_q, load_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // Captured request and working accumulators.
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  md_op_e           op_q, op_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier+product low / dividend+quotient
  logic [WIDTH-1:0] m_q, m_d;             // multiplicand or divisor magnitude

  logic             is_div, a_neg, b_neg, div_zero, accept;
  logic [WIDTH-1:0] mag_a, mag_b, addend, quo_fix, rem_fix;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] product, prod_fix;

  assign md_busy = load_q || (state_q == ST_CALC) || (state_q == ST_FIX);
  assign md_done = (state_q == ST_DONE);
  assign accept  = md_start && !md_busy;
  assign hi      = hi_q;
  assign lo      = lo_q;

  // Operand signs, magnitudes and per-step arithmetic.
  always_comb begin
    is_div    = op_is_div(op_q);
    a_neg     = op_is_signed(op_q) && a_q[WIDTH-1];
    b_neg     = op_is_signed(op_q) && b_q[WIDTH-1];
    div_zero  = is_div && (b_q == '0);
    mag_a     = a_neg ? -a_q : a_q;
    mag_b     = b_neg ? -b_q : b_q;
    addend    = acc_lo_q[0] ? m_q : {WIDTH{1'b0}};
    mul_sum   = acc_hi_q + {1'b0, addend};
    div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};
    product   = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    prod_fix  = (a_neg ^ b_neg) ? -product : product;
    quo_fix   = (a_neg ^ b_neg) ? -acc_lo_q : acc_lo_q;
    rem_fix   = a_neg ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
  end

  // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    // NOTE: every *_d is given a hold value first so no path through the
    // case leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    load_d   = 1'b0;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    m_d      = m_q;

    if (accept) begin
      a_d     = a;
      b_d     = b;
      op_d    = md_op_e'(md_op);
      load_d  = 1'b1;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_q) begin
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = is_div ? mag_a : mag_b;
            m_d      = is_div ? mag_b : mag_a;
            state_d  = div_zero ? ST_FIX : ST_CALC;
          end
        end
        ST_CALC: begin
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              acc_hi_d = div_diff;
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_d = div_shift;
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_FIX: begin
          if (div_zero) begin
            hi_d = a_q;
            lo_d = '1;
          end else if (is_div) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;  // ST_DONE lasts one cycle
      endcase
    end
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand and accumulator registers.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are always written by the accept/load
    // cycles before any state reads them.
    a_q      <= a_d;
    b_q      <= b_d;
    op_q     <= op_d;
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
    m_q      <= m_d;
  end

endmodule

// File: rtl/alu_md.sv
// ALU with a combinational result path and an attached iterative
// multiply/divide unit; the two paths are fully independent.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH_D = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH_D-1:0] a,
  input  logic [WIDTH_D-1:0] b,
  input  logic [3:0]         alu_ctrl,
  output logic [WIDTH_D-1:0] y,
  output logic               zero,
  input  logic               md_start,
  input  logic [1:0]         md_op,
  output logic               md_busy,
  output logic               md_done,
  output logic [WIDTH_D-1:0] hi,
  output logic [WIDTH_D-1:0] lo
);

  // Single-cycle ALU result; unknown codes give zero.
  always_comb begin
    y = '0;
    case (alu_ctrl_e'(alu_ctrl))
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {{(WIDTH_D-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

  muldiv_iter #(
    .WIDTH (WIDTH_D)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .md_start (md_start),
    .md_op    (md_op),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH_D=32): a behavioural model built on
// plain integer arithmetic is compared every cycle, and directed vectors pin
// hand-computed results and latencies.
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  a, b, y, hi, lo;
  logic [3:0]    alu_ctrl;
  logic          zero, md_start, md_busy, md_done;
  logic [1:0]    md_op;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  bit checking = 1'b0;

  // Model state, advanced on every rising edge.
  int           cyc     = 0;
  int           done_at = -1;
  int           free_at = 0;
  bit           pend    = 1'b0;
  bit           done_valid = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  alu_md #(.WIDTH_D(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .alu_ctrl (alu_ctrl),
    .y        (y),
    .zero     (zero),
    .md_start (md_start),
    .md_op    (md_op),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] alu_model(input logic [3:0] c, input logic [W-1:0] x,
                                             input logic [W-1:0] z);
    case (c)
      4'b0000: return x & z;
      4'b0001: return x | z;
      4'b0010: return x + z;
      4'b0110: return x - z;
      4'b0111: return (int'(x) < int'(z)) ? 32'd1 : 32'd0;
      4'b1100: return ~(x | z);
      default: return '0;
    endcase
  endfunction

  // Returns {hi, lo}.
  function automatic logic [63:0] md_model(input logic [1:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] z);
    longint sp;
    int     q, r;
    case (op)
      2'b00: return {32'b0, x} * {32'b0, z};
      2'b01: begin
        sp = longint'(int'(x)) * longint'(int'(z));
        return sp;
      end
      2'b10: begin
        if (z == 0) return {x, 32'hFFFF_FFFF};
        return {x % z, x / z};
      end
      default: begin
        if (z == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = int'(x) / int'(z);
        r = int'(x) % int'(z);
        return {r, q};
      end
    endcase
  endfunction

  // Model: acceptance, latency and result update per the rules of the block.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      pend       = 1'b0;
      done_valid = 1'b0;
      m_hi       = '0;
      m_lo       = '0;
      free_at    = cyc + 1;
    end else begin
      if (pend && cyc == done_at) begin
        m_hi = p_hi;
        m_lo = p_lo;
        pend = 1'b0;
      end
      if (md_start && cyc >= free_at) begin
        {p_hi, p_lo} = md_model(md_op, a, b);
        done_at    = cyc + ((md_op[1] && b == 0) ? 2 : W + 2);
        free_at    = done_at + 1;
        pend       = 1'b1;
        done_valid = 1'b1;
      end
    end
  end

  // Compare process: every output against the model on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      check("cmp_y",    y,    alu_model(alu_ctrl, a, b));
      check("cmp_zero", zero, alu_model(alu_ctrl, a, b) == '0);
      check("cmp_busy", md_busy, pend);
      check("cmp_done", md_done, done_valid && cyc == done_at);
      check("cmp_hi",   hi,   m_hi);
      check("cmp_lo",   lo,   m_lo);
    end
    if (md_done === 1'b1) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_md(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] z,
                          output int e0);
    md_op    = op;
    a        = x;
    b        = z;
    md_start = 1'b1;
    step();
    e0       = cyc;
    md_start = 1'b0;
    a        = $urandom;
    b        = $urandom;
    md_op    = 2'($urandom);
    alu_ctrl = 4'($urandom);
  endtask

  task automatic finish_md(input int e0, input int exp_lat, input logic [W-1:0] ehi,
                           input logic [W-1:0] elo, input string name);
    int lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (md_done === 1'b1) begin
        lat = cyc - e0;
        break;
      end
      step();
    end
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_hi"},  hi,  ehi);
    check({name, "_lo"},  lo,  elo);
  endtask

  task automatic run_md(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] z,
                        input int exp_lat, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input string name);
    int e0;
    start_md(op, x, z, e0);
    finish_md(e0, exp_lat, ehi, elo, name);
  endtask

  typedef struct {
    logic [3:0]   c;
    logic [W-1:0] x, z, yy;
    logic         zr;
  } alu_vec_t;

  alu_vec_t vecs [10];

  initial begin
    int e0, e1, d0;

    vecs = '{
      '{4'b0110, 32'd7,          32'd9,          32'hFFFF_FFFE, 1'b0},
      '{4'b0111, 32'd7,          32'd9,          32'h0000_0001, 1'b0},
      '{4'b0111, 32'h8000_0000,  32'd1,          32'h0000_0001, 1'b0},
      '{4'b0111, 32'h7FFF_FFFF,  32'h8000_0000,  32'h0000_0000, 1'b1},
      '{4'b0010, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b1},
      '{4'b0010, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000, 1'b0},
      '{4'b0000, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, 1'b0},
      '{4'b0001, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0, 1'b0},
      '{4'b1100, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h000F_000F, 1'b0},
      '{4'b1111, 32'd5,          32'd5,          32'h0000_0000, 1'b1}
    };

    rst_n = 1'b0; md_start = 1'b0; md_op = 2'b00;
    a = '0; b = '0; alu_ctrl = 4'b0000;
    repeat (2) step();
    checking = 1'b1;
    check("rst_busy", md_busy, 1'b0);
    check("rst_done", md_done, 1'b0);
    check("rst_hi",   hi, 32'h0);
    check("rst_lo",   lo, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      alu_ctrl = vecs[i].c;
      a        = vecs[i].x;
      b        = vecs[i].z;
      #1;
      check($sformatf("alu%0d_y", i),    y,    vecs[i].yy);
      check($sformatf("alu%0d_zero", i), zero, vecs[i].zr);
      step();
    end

    run_md(2'b01, 32'hFFFF_FFFE, 32'd3, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    step();
    run_md(2'b00, 32'hFFFF_FFFE, 32'd3, 34, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
    step();
    run_md(2'b11, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    step();
    run_md(2'b10, 32'h64, 32'd7, 34, 32'h2, 32'hE, "divu");
    step();
    run_md(2'b10, 32'h1234, 32'd0, 2, 32'h1234, 32'hFFFF_FFFF, "divu0");
    step();
    run_md(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, "divmin");
    step();
    run_md(2'b11, 32'd7, 32'hFFFF_FFFE, 34, 32'h1, 32'hFFFF_FFFD, "divneg");
    step();
    run_md(2'b01, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0, "multmin");
    step();

    // A request during a busy operation is ignored.
    start_md(2'b00, 32'd5, 32'd6, e0);
    repeat (9) step();
    md_op = 2'b10; a = 32'd1; b = 32'd0; md_start = 1'b1;
    step();
    md_start = 1'b0;
    d0 = n_done;
    finish_md(e0, 34, 32'h0, 32'h1E, "ignore");
    repeat (40) step();
    check("ignore_single_done", n_done - d0, 1);

    // Back-to-back: a request during DONE is accepted.
    start_md(2'b10, 32'h64, 32'd7, e0);
    finish_md(e0, 34, 32'h2, 32'hE, "b2b_first");
    start_md(2'b01, 32'hFFFF_FFFE, 32'd3, e1);
    finish_md(e1, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "b2b_second");
    step();

    // Reset at cycle 15 of a MULT, with md_start raised at the same edge.
    start_md(2'b01, 32'hFFFF_FFFE, 32'd3, e0);
    repeat (14) step();
    rst_n = 1'b0; md_start = 1'b1; md_op = 2'b10; b = 32'd0;
    step();
    rst_n = 1'b1; md_start = 1'b0;
    check("rst_mid_busy", md_busy, 1'b0);
    check("rst_mid_hi",   hi, 32'h0);
    check("rst_mid_lo",   lo, 32'h0);
    d0 = n_done;
    repeat (40) step();
    check("rst_mid_no_done", n_done - d0, 0);

    run_md(2'b00, 32'd12, 32'd11, 34, 32'h0, 32'd132, "after_rst");
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter WIDTH_D, default 32, data width; legal values are even and 8 or more.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports a, b  input  WIDTH_D  operands.
REQ-005 SHALL have port alu_ctrl  input  4  combinational op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR.
REQ-006 SHALL have ports y  output  WIDTH_D  combinational result, and zero  output  1  high when y is all zeros.
REQ-007 SHALL have ports md_start  input  1  request, and md_op  input  2  op select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-008 SHALL have ports md_busy  output  1, md_done  output  1  one-cycle completion pulse, and hi, lo  output  WIDTH_D  results.

Function
REQ-009 SHALL compute y and zero combinationally, in the same cycle, independent of multiply/divide state.
REQ-010 SHALL drive y to zero for any undefined alu_ctrl code; y SHALL never be X or Z.
REQ-011 SHALL wrap ADD and SUB modulo 2^WIDTH_D; SLT SHALL give 1 or 0 in bit 0 and signed compare correctly when a-b overflows.
REQ-012 SHALL implement the multiply/divide FSM with states IDLE, CALC, FIX and DONE.
REQ-013 SHALL accept a request when md_start=1 and md_busy=0 at an edge E0, capturing a, b and md_op at E0.
REQ-014 SHALL stay in CALC for exactly WIDTH_D cycles after E0, performing one shift-add (multiply) or one restoring step (divide) per cycle on operand magnitudes.
REQ-015 SHALL apply sign correction in FIX (one cycle), then enter DONE.
REQ-016 SHALL update hi and lo at the edge that enters DONE, which is E0+WIDTH_D+2.
REQ-017 SHALL assert md_done for exactly that one DONE cycle, then return to IDLE unless a new request is accepted.
REQ-018 SHALL assert md_busy in CALC and FIX only, so that a md_start during DONE is accepted (back-to-back requests).
REQ-019 SHALL ignore md_start while md_busy=1; changes on a, b and md_op after E0 SHALL have no effect.
REQ-020 SHALL produce the full product for multiply: hi holds the upper WIDTH_D bits and lo the lower WIDTH_D bits; MULT is signed and MULTU is unsigned.
REQ-021 SHALL produce lo = quotient and hi = remainder for divide; for DIV the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-022 SHALL, on divide by zero, skip CALC and go IDLE->FIX->DONE, with md_done at E0+2, lo = all ones and hi = a.
REQ-023 SHALL, for DIV of the most negative value by -1, give lo = most negative value and hi = 0 at normal latency.
REQ-024 SHALL hold hi and lo stable between completions.

Reset
REQ-025 SHALL, when rst_n=0 at an edge, enter IDLE with md_busy=0, md_done=0, hi=0, lo=0 and the iteration counter at 0.
REQ-026 SHALL, on reset mid-operation, abort the operation with no md_done pulse and leave hi and lo at 0.
REQ-027 SHALL give reset priority over md_start at the same edge.

Structure
REQ-028 SHALL place the alu_ctrl codes, md_op codes and FSM state encodings in a shared package, alu_md_pkg.
REQ-029 SHALL place the iterative engine (FSM, counter, accumulators, sign fix) in one sub-module, muldiv_iter; alu_md SHALL hold the combinational ALU and instantiate muldiv_iter.

Verification (WIDTH_D=32)
REQ-030 SHALL check the ALU ops: a=7, b=9 gives SUB y=FFFFFFFE with zero=0 and SLT y=1; a=80000000, b=1 gives SLT y=1; ADD of FFFFFFFF and 1 gives y=0 with zero=1.
REQ-031 SHALL check MULT a=FFFFFFFE (-2), b=3: md_done exactly 34 cycles after the accepting edge, hi=FFFFFFFF, lo=FFFFFFFA; MULTU of the same operands gives hi=2, lo=FFFFFFFA.
REQ-032 SHALL check DIV a=FFFFFFF9 (-7), b=2: lo=FFFFFFFD and hi=FFFFFFFF; DIVU a=64, b=7: lo=E, hi=2.
REQ-033 SHALL check DIVU a=1234, b=0: md_done at E0+2, lo=FFFFFFFF, hi=1234; DIV a=80000000, b=FFFFFFFF: lo=80000000, hi=0.
REQ-034 SHALL check a second md_start at cycle 10 of a busy operation (ignored, single md_done) and a md_start during DONE (accepted, second md_done 34 cycles later).
REQ-035 SHALL check rst_n=0 at cycle 15 of a MULT: next cycle md_busy=0, hi=lo=0, and no md_done occurs.
